// File: rtl/sortnet_pkg.sv
// sortnet_pkg: shared sorting-network widths, unloader states and lane-slice helper
package sortnet_pkg;
  localparam int DATA_WIDTH = 4;
  localparam int N = 8;
  localparam int IDX_W = $clog2(N);
  localparam int VEC_W = N * DATA_WIDTH;
  typedef enum logic {IDLE, STREAM} state_e;
  function automatic logic [DATA_WIDTH-1:0] lane(input logic [VEC_W-1:0] v, input logic [IDX_W-1:0] i);
    return v[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction
endpackage

// File: rtl/sorted_unloader_if.sv
// sorted_unloader_if: vector capture port plus element stream port of the unloader
interface sorted_unloader_if;
  import sortnet_pkg::*;
  logic x_valid, x_rev, x_ready, m_valid, m_ready, m_last, overflow, ovf_clr;
  logic [VEC_W-1:0] x_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic [IDX_W-1:0] m_index;
  modport slave(input x_valid, x_data, x_rev, m_ready, ovf_clr,
                output x_ready, m_valid, m_data, m_index, m_last, overflow);
  modport master(output x_valid, x_data, x_rev, m_ready, ovf_clr,
                 input x_ready, m_valid, m_data, m_index, m_last, overflow);
endinterface

// File: rtl/vec_slot.sv
// vec_slot: one buffered vector (valid, data, direction) with load and clear
module vec_slot import sortnet_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [VEC_W-1:0] data_i,
  input  logic             rev_i,
  output logic             valid_o,
  output logic [VEC_W-1:0] data_o,
  output logic             rev_o
);
  logic valid_q, rev_q;
  logic [VEC_W-1:0] data_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rev_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      rev_q   <= rev_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign rev_o   = rev_q;
endmodule

// File: rtl/sorted_unloader.sv
// sorted_unloader: streams each captured sorted vector one element per beat
module sorted_unloader import sortnet_pkg::*; (
  input logic clk,
  input logic rst,
  sorted_unloader_if.slave s
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  logic act_v, act_rev, pnd_v, pnd_rev;
  logic [VEC_W-1:0] act_data, pnd_data;
  state_e state_q;
  logic [IDX_W-1:0] cnt_q;
  logic ovf_q;
  logic cap, drop, acc, last_acc, cap_act, act_load, act_clr, pnd_load, pnd_clr;
  assign cap      = s.x_valid & ~pnd_v;
  assign drop     = s.x_valid & pnd_v;
  assign acc      = s.m_valid & s.m_ready;
  assign last_acc = acc & (cnt_q == LAST);
  // a capture can only happen with pending empty, so a freeing last beat sends it straight to active
  assign cap_act  = cap & (~act_v | last_acc);
  assign act_load = cap_act | (last_acc & pnd_v);
  assign act_clr  = last_acc & ~pnd_v & ~cap;
  assign pnd_load = cap & ~cap_act;
  assign pnd_clr  = last_acc & pnd_v;
  vec_slot u_act (
    .clk(clk), .rst(rst), .load_i(act_load), .clr_i(act_clr),
    .data_i(pnd_v ? pnd_data : s.x_data), .rev_i(pnd_v ? pnd_rev : s.x_rev),
    .valid_o(act_v), .data_o(act_data), .rev_o(act_rev)
  );
  vec_slot u_pnd (
    .clk(clk), .rst(rst), .load_i(pnd_load), .clr_i(pnd_clr),
    .data_i(s.x_data), .rev_i(s.x_rev),
    .valid_o(pnd_v), .data_o(pnd_data), .rev_o(pnd_rev)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= act_load ? STREAM : act_clr ? IDLE : state_q;
      cnt_q   <= acc ? cnt_q + 1'b1 : cnt_q;
      ovf_q   <= drop | (ovf_q & ~s.ovf_clr);
    end
  assign s.x_ready  = ~pnd_v;
  assign s.m_valid  = state_q == STREAM;
  assign s.m_index  = act_rev ? LAST - cnt_q : cnt_q;
  assign s.m_data   = lane(act_data, s.m_index);
  assign s.m_last   = s.m_valid & (cnt_q == LAST);
  assign s.overflow = ovf_q;
endmodule

// File: tb/tb_sorted_unloader.sv
// tb_sorted_unloader: randomized scoreboard bench for the sorted vector unloader
module tb_sorted_unloader;
  import sortnet_pkg::*;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic [IDX_W-1:0]      i;
    logic                  l;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  sorted_unloader_if bus();
  sorted_unloader dut (.clk(clk), .rst(rst), .s(bus.slave));
  beat_t sb[$];
  int captured = 0;
  int acc = 0;
  int passed = 0;
  int total = 0;
  logic exp_ovf = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask
  // vectors still held by the unloader: captured minus fully accepted
  function automatic int inbuf();
    return captured - acc / N;
  endfunction
  function automatic void push_vec(input logic [VEC_W-1:0] v, input logic r);
    for (int k = 0; k < N; k++) begin
      beat_t b;
      int ln;
      ln = r ? N - 1 - k : k;
      b.d = v[ln*DATA_WIDTH +: DATA_WIDTH];
      b.i = IDX_W'(ln);
      b.l = (k == N - 1);
      sb.push_back(b);
    end
  endfunction
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      sb.delete();
      captured = 0;
      acc = 0;
      exp_ovf = 1'b0;
    end else begin
      int outstanding;
      logic drop;
      outstanding = captured * N - acc;
      drop = bus.x_valid && inbuf() >= 2;
      if (drop) exp_ovf = 1'b1;
      else if (bus.ovf_clr) exp_ovf = 1'b0;
      if (bus.x_valid && !drop) begin
        push_vec(bus.x_data, bus.x_rev);
        captured++;
      end
      if (bus.m_ready && outstanding > 0) acc++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("x_ready", 32'(bus.x_ready), 32'(inbuf() < 2));
      chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
      chk("m_valid", 32'(bus.m_valid), 32'(sb.size() > 0));
      if (bus.m_valid && sb.size() > 0) begin
        chk("m_data", 32'(bus.m_data), 32'(sb[0].d));
        chk("m_index", 32'(bus.m_index), 32'(sb[0].i));
        chk("m_last", 32'(bus.m_last), 32'(sb[0].l));
        if (bus.m_ready) void'(sb.pop_front());
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [VEC_W-1:0] d, input logic r);
    bus.x_valid = 1'b1;
    bus.x_data = d;
    bus.x_rev = r;
    step();
    bus.x_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) step();
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    step();
  endtask
  initial begin
    bus.x_valid = 1'b0;
    bus.x_data = '0;
    bus.x_rev = 1'b0;
    bus.m_ready = 1'b1;
    bus.ovf_clr = 1'b0;
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_index", 32'(bus.m_index), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_x_ready", 32'(bus.x_ready), 32'd1);
    step();
    rst = 1'b1;
    step();
    send(32'h8765_4321, 1'b0);
    drain();
    send(32'h8765_4321, 1'b1);
    drain();
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    drain();
    bus.m_ready = 1'b0;
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    send($urandom, 1'b0);
    step();
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    bus.m_ready = 1'b1;
    drain();
    send($urandom, 1'($urandom));
    for (int i = 0; i < 40; i++) begin
      bus.m_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    bus.m_ready = 1'b1;
    drain();
    for (int i = 0; i < 400; i++) begin
      bus.x_valid = ($urandom_range(0, 3) == 0);
      bus.x_data = $urandom;
      bus.x_rev = 1'($urandom);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.x_valid = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.m_ready = 1'b1;
    drain();
    bus.m_ready = 1'b0;
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    send($urandom, 1'b0);
    bus.m_ready = 1'b1;
    repeat (3) step();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst_m_index", 32'(bus.m_index), 32'd0);
    chk("midrst_m_last", 32'(bus.m_last), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    chk("midrst_x_ready", 32'(bus.x_ready), 32'd1);
    step();
    rst = 1'b1;
    repeat (20) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sorted_unloader.md
# sorted_unloader

Output end of the bitonic sorting network: captures each sorted N-element vector on the network's final-stage valid pulse and streams its elements out one per beat over a valid/ready interface. A two-slot (active + pending) buffer absorbs back-to-back vectors; a vector arriving with both slots full is dropped and flagged. Per-vector direction select lets one network serve both ascending and descending consumers without re-sorting.

## Interface
- DATA_WIDTH, 4, element width in bits (matches the network's compare-and-exchange width)
- N, 8, elements per vector; power of two, N >= 2
- IDX_W, $clog2(N), width of the element index
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately, released synchronously by system
- x_valid  in  1  one-cycle pulse: x_data holds a complete sorted vector
- x_data  in  N*DATA_WIDTH  element i at bits [i*DATA_WIDTH +: DATA_WIDTH]; element 0 is the network's first output lane
- x_rev  in  1  sampled with x_valid: 0 streams element 0 first, 1 streams element N-1 first
- x_ready  out  1  combinational, = ~pending_valid; a vector is captured only when x_valid & x_ready
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  current element
- m_index  out  IDX_W  physical lane index of m_data within its vector
- m_last  out  1  m_valid and beat count == N-1
- overflow  out  1  sticky: a vector was dropped
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Two slots, each {valid, data[N*DATA_WIDTH], rev}. Active slot drives output; pending slot queues one vector.
- Beat counter cnt (IDX_W bits) counts accepted beats of active vector, 0..N-1, wraps to 0 after last beat.
- m_index = rev ? N-1-cnt : cnt; m_data = element m_index of active data; m_valid = active_valid.
- States: IDLE (active empty), STREAM (active valid). Pending valid only possible in STREAM.
- Capture (x_valid & x_ready): goes to active if active empty, or active's last beat accepted this same edge and pending empty; else to pending.
- Beat accept (m_valid & m_ready): cnt+1. On last beat: if pending valid, pending -> active, pending cleared, stay STREAM; else if capture this edge, new vector -> active; else -> IDLE.
- x_valid & ~x_ready: vector dropped, overflow <= 1. ovf_clr and drop same edge: overflow = 1 (set wins).
- While m_valid & ~m_ready: m_data, m_index, m_last held stable.
- Reset mid-stream: both slots invalidated, cnt = 0, in-flight vectors discarded; no partial replay.

## Timing
- Reset values: m_valid 0, m_data 0, m_index 0, m_last 0, overflow 0, cnt 0, slots empty; x_ready 1 during and after reset.
- Latency: capture at edge T, first beat m_valid = 1 in cycle after T.
- Throughput: with m_ready held 1, one element per cycle; vector boundaries zero-bubble when pending is loaded (last beat of vector k, next cycle first beat of k+1).
- Minimum vector spacing without loss at full m_ready: N cycles; pulses closer than that fill pending, then drop.
- x_ready falls the cycle after pending is loaded; rises the cycle after pending moves to active.
- Arithmetic: unsigned; cnt compare to N-1 uses IDX_W bits; no width extension of data.

## Structure
- Shared package sortnet_pkg: DATA_WIDTH/N defaults, IDX_W derivation, element-slice helper function (lane i of a packed vector), also used by the network top.
- One sub-module: vec_slot (valid, data, rev register with load/clear), instantiated twice for active and pending.
- Output mux and FSM/counter in sorted_unloader.

## Test plan
- N=8, W=4: x_data lanes 0..7 = 1,2,3,4,5,6,7,8, x_rev=0, m_ready=1 -> m_data 1..8 on 8 consecutive cycles starting cycle after capture, m_index 0..7, m_last only on 8.
- Same vector, x_rev=1 -> m_data 8,7,...,1, m_index 7..0, m_last with value 1.
- Two pulses 1 cycle apart, m_ready=1 -> 16 contiguous beats, no bubble at boundary; x_ready low from cycle after 2nd capture until first vector's last beat +1.
- Three pulses back-to-back with m_ready=0 -> third dropped, overflow=1, x_ready=0; ovf_clr -> overflow=0; release m_ready -> exactly 16 beats.
- m_ready toggling 1,0,0,1,... on vector 9..16 -> each value held while stalled; output sequence unchanged, no duplicates.
- rst low during beat 3 -> m_valid, m_index, overflow 0 immediately; x_ready 1; after release no residual beats.
